// File: rtl/sbus_mem_ctl.sv
`timescale 1ns / 1ps
// Memory-side responder for SBUS quad-word cycles. It acknowledges a START,
// returns read words in wrap order, captures write words, checks address and
// data parity, and supports a MEM_RESET abort. Storage is an internal array.
//
// Bit numbering: adr[1:0] is ADR[34:35] (the quad-word offset) and adr[21:2]
// is ADR[14:33]. rq[i] requests the word at quad-word offset i.
module sbus_mem_ctl #(
  parameter int unsigned ADR_BITS   = 12,
  parameter int unsigned ACK_DLY    = 2,
  parameter int unsigned RD_DLY     = 1,
  parameter int unsigned WR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_reset,
  input  logic        start_a,
  input  logic        start_b,
  input  logic [3:0]  rq,
  input  logic        rd_rq,
  input  logic        wr_rq,
  input  logic [21:0] adr,
  input  logic        adr_par,
  output logic        ackn_a,
  output logic        ackn_b,
  output logic        data_valid_out_a,
  output logic        data_valid_out_b,
  output logic [35:0] d_out,
  output logic        data_par_out,
  input  logic        data_valid_in_a,
  input  logic        data_valid_in_b,
  input  logic [35:0] d_in,
  input  logic        data_par_in,
  output logic        error,
  output logic        adr_par_err,
  output logic        busy
);

  localparam int unsigned CntW    = 16;
  localparam int unsigned AckLast = (ACK_DLY > 1) ? ACK_DLY - 2 : 0;
  localparam int unsigned RdLast  = (RD_DLY > 1) ? RD_DLY - 2 : 0;
  localparam int unsigned WrLast  = (WR_TIMEOUT > 0) ? WR_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    StIdle,
    StAckWait,
    StAck,
    StRdGap,
    StRdData,
    StWrData
  } state_e;

  state_e          state_q, state_d;
  logic            side_q, side_d;    // 0: controller A, 1: controller B
  logic [21:0]     adr_q, adr_d;
  logic [3:0]      rq_q, rq_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [3:0]      pend_q, pend_d;    // requested offsets not yet transferred
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            ape_q, ape_d;

  logic [1:0]          cur_off;
  logic [3:0]          cur_bit;
  logic                last_word;
  logic [21:0]         full_idx;
  logic [ADR_BITS-1:0] mem_idx;
  logic                unused_idx;
  logic                mem_we;
  logic                dv_in;
  logic                rd_word;
  logic [35:0]         mem [2**ADR_BITS];

  // Pick the first pending offset in wrap order starting at the latched offset.
  always_comb begin
    cur_off = adr_q[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[adr_q[1:0] + 2'(i)]) cur_off = adr_q[1:0] + 2'(i);
    end
  end

  assign cur_bit    = 4'b0001 << cur_off;
  assign last_word  = (pend_q & ~cur_bit) == 4'b0000;
  assign full_idx   = {adr_q[21:2], cur_off};
  assign mem_idx    = full_idx[ADR_BITS-1:0];
  assign unused_idx = ^full_idx;
  assign dv_in      = side_q ? data_valid_in_b : data_valid_in_a;

  // Next-state logic for the cycle sequencer.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    adr_d   = adr_q;
    rq_d    = rq_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    ape_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((start_a || start_b) && (rd_rq || wr_rq)) begin
          if (^{adr, adr_par}) begin
            side_d  = !start_a;
            adr_d   = adr;
            rq_d    = rq;
            rd_d    = rd_rq;
            wr_d    = wr_rq;
            pend_d  = rq;
            cnt_d   = '0;
            state_d = (ACK_DLY > 1) ? StAckWait : StAck;
          end else begin
            err_d = 1'b1;
            ape_d = 1'b1;
          end
        end
      end
      StAckWait: begin
        if (cnt_q == CntW'(AckLast)) begin
          cnt_d   = '0;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        cnt_d = '0;
        if (rq_q == 4'b0000) state_d = StIdle;
        else if (rd_q)       state_d = (RD_DLY > 1) ? StRdGap : StRdData;
        else                 state_d = StWrData;
      end
      StRdGap: begin
        if (cnt_q == CntW'(RdLast)) begin
          cnt_d   = '0;
          state_d = StRdData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdData: begin
        pend_d = pend_q & ~cur_bit;
        if (last_word) begin
          if (wr_q) begin
            // Read-pause-write: replay the same word order for the write half.
            pend_d  = rq_q;
            cnt_d   = '0;
            state_d = StWrData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWrData: begin
        if (dv_in) begin
          cnt_d  = '0;
          pend_d = pend_q & ~cur_bit;
          // A word with bad parity is dropped but still consumes its offset.
          if (^{d_in, data_par_in}) mem_we = 1'b1;
          else                      err_d  = 1'b1;
          if (last_word) state_d = StIdle;
        end else if (cnt_q == CntW'(WrLast)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything else in this cycle.
    if (mem_reset) begin
      state_d = StIdle;
      cnt_d   = '0;
      pend_d  = '0;
      err_d   = 1'b0;
      ape_d   = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // Sequencer state and error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      side_q  <= 1'b0;
      adr_q   <= '0;
      rq_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ape_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      adr_q   <= adr_d;
      rq_q    <= rq_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ape_q   <= ape_d;
    end
  end

  // Word array write port; contents survive both resets.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= d_in;
  end

  assign rd_word          = (state_q == StRdData);
  assign ackn_a           = (state_q == StAck) && !side_q;
  assign ackn_b           = (state_q == StAck) && side_q;
  assign data_valid_out_a = rd_word && !side_q;
  assign data_valid_out_b = rd_word && side_q;
  assign d_out            = rd_word ? mem[mem_idx] : 36'd0;
  assign data_par_out     = ~^d_out;
  assign error            = err_q;
  assign adr_par_err      = ape_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: doc/sbus_mem_ctl.md
Name: sbus_mem_ctl

Overview:
- Simulated SBUS internal-memory controller. It sits directly downstream of the MBOX-side SBUS translator and answers the START/RQ/ADR cycles that the translator forwards.
- Implements the memory side of the quad-word protocol: ACKN, wrap-ordered read data with DATA_VALID, and write-data capture.
- Checks address and data parity, reports errors, and supports MEM_RESET abort.
- Storage is an internal word array; no real core timing is modelled beyond configurable delays.

Parameters:
- ADR_BITS, 12, number of low physical-address bits that index the internal array (2**ADR_BITS 36-bit words).
- ACK_DLY, 2, cycles from accepted START to the ACKN pulse (minimum 1).
- RD_DLY, 1, cycles from ACKN to the first read DATA_VALID (minimum 1).
- WR_TIMEOUT, 16, cycles to wait for each write DATA_VALID before aborting with ERROR.

Ports:
- CLK in 1 SBUS clock; all state changes on its rising edge.
- RESET_N in 1 asynchronous active-low reset.
- MEM_RESET in 1 synchronous abort to IDLE; memory contents are preserved.
- START_A, START_B in 1 each; one-cycle cycle-start strobes for controller A/B.
- RQ in 4 [0:3] word-request mask, one bit per quad word.
- RD_RQ, WR_RQ in 1 each; read and/or write cycle.
- ADR in 22 [14:35] physical address.
- ADR_PAR in 1 odd parity over ADR.
- ACKN_A, ACKN_B out 1 each; acknowledge, one-cycle pulse.
- DATA_VALID_OUT_A, DATA_VALID_OUT_B out 1 each; read word valid.
- D_OUT out 36 [0:35] read data.
- DATA_PAR_OUT out 1 odd parity over D_OUT.
- DATA_VALID_IN_A, DATA_VALID_IN_B in 1 each; write word valid from MBOX.
- D_IN in 36 write data.
- DATA_PAR_IN in 1 odd parity over D_IN.
- ERROR out 1 one-cycle error pulse.
- ADR_PAR_ERR out 1 one-cycle address-parity-error pulse.
- BUSY out 1 high in every state except IDLE.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State becomes IDLE.
  - All outputs are 0, including D_OUT; DATA_PAR_OUT is 1 (odd parity of zero).
  - Array contents are undefined until written.
- States: IDLE, ACK_WAIT, ACK, RD_GAP, RD_DATA, WR_DATA.
- IDLE:
  - START_A or START_B latches ADR, RQ, RD_RQ, WR_RQ and the side (A wins if both are asserted).
  - Parity check: ^ADR ^ ADR_PAR must equal 1.
  - On parity failure: ADR_PAR_ERR and ERROR pulse in the next cycle, no ACKN, state stays IDLE.
  - START with neither RD_RQ nor WR_RQ set is ignored.
- ACK_WAIT: counts ACK_DLY-1 cycles, then goes to ACK.
- ACK:
  - ACKN on the latched side is high for exactly one cycle.
  - Next state: RD_GAP if RD_RQ, else WR_DATA if WR_RQ.
  - RQ == 0: ACK only, then IDLE.
- Word order:
  - Start offset s = ADR[34:35]; visit offsets s, s+1, s+2, s+3 mod 4.
  - Only offsets with RQ[offset] = 1 are processed; unrequested offsets cost zero cycles.
  - Array index = {ADR[14:33], offset}, low ADR_BITS bits.
- RD_GAP: RD_DLY-1 cycles of idle outputs, then RD_DATA.
- RD_DATA:
  - One requested word per cycle: DATA_VALID_OUT on the latched side = 1, with D_OUT and DATA_PAR_OUT valid in the same cycle.
  - D_OUT returns to 0 when no data is valid.
  - After the last requested word: WR_DATA if WR_RQ (read-pause-write, same word order), else IDLE.
- WR_DATA:
  - Waits for DATA_VALID_IN on the latched side.
  - Each valid cycle consumes the next requested offset and writes D_IN.
  - Data parity error (^D_IN ^ DATA_PAR_IN == 0): ERROR pulses next cycle, the word is NOT written, sequencing continues.
  - Timeout counter reloads per word; on expiry, ERROR pulses and state goes to IDLE.
  - After the last word: IDLE.
- Busy rule: START strobes while BUSY are ignored, with no error.
- MEM_RESET high in any state: next state IDLE, counters cleared, outputs 0, no ERROR. It has priority over all other events in that cycle.
- Back-to-back cycles: a START in the cycle BUSY falls is accepted.

Test Plan:
- Read, all words, wrapped start: preload words 0x100..0x103 = 1,2,3,4. START_A, RD_RQ, RQ=1111, ADR=0x103, good parity → ACKN_A 2 cycles later; data 4,1,2,3 on consecutive cycles starting 1 cycle after ACKN; DATA_VALID_OUT_B stays 0.
- Sparse write: START_B, WR_RQ, RQ=0101, ADR=0x200 → ACKN_B. Feed D_IN=0o777 then 0o123 with DATA_VALID_IN_B → words 0x200 and 0x202 written; 0x201 and 0x203 unchanged on readback.
- Address parity error: ADR_PAR wrong on START_A → ADR_PAR_ERR and ERROR high for 1 cycle, no ACKN, BUSY stays 0.
- Bad write-data parity on the 2nd of 2 words → ERROR pulse; that word retains its old value, the first word is written; state returns to IDLE.
- Write timeout: WR_RQ, RQ=1000, no DATA_VALID_IN for 16 cycles → ERROR pulse, IDLE; a subsequent START is accepted.
- Abort: MEM_RESET asserted mid RD_DATA after 2 of 4 words → next cycle all outputs 0, BUSY 0, no further DATA_VALID; array contents unchanged.
